// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a FIFO, with local occupancy tracking and stall counting.
// Optional winner lock (up to 4 back-to-back grants) is enabled by defining WR_ARB_LOCK_EN.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata_in,
    input  logic                    fifo_full,
    input  logic                    fifo_rd_en,
    output logic [NREQ-1:0]         gnt,
    output logic                    fifo_wr_en,
    output logic [WIDTH-1:0]        fifo_wdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic [7:0]              stall_cnt,
    output logic [1:0]              state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW:0]   DEPTH_EXT = DEPTH[CW:0];
    localparam logic [CW-1:0] DEPTH_CNT = DEPTH[CW-1:0];
    localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StBlocked = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                wr_en_q, wr_en_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic [CW-1:0]       count_q, count_d;
    logic [7:0]          stall_q, stall_d;
    logic [PW-1:0]       ptr_q, ptr_d;

    logic                can_grant;
    logic [CW:0]         occ_sum;
    logic [PW-1:0]       search_start;
    logic                win_found;
    logic [PW-1:0]       win_idx;

    // A push already in flight counts against free space.
    assign occ_sum   = {1'b0, count_q} + {{CW{1'b0}}, wr_en_q};
    assign can_grant = (|req) && !fifo_full && (occ_sum < DEPTH_EXT);

`ifdef WR_ARB_LOCK_EN
    logic [PW-1:0] last_q, last_d;
    logic [2:0]    run_q, run_d;
    logic          lock_active;

    assign lock_active  = (run_q != 3'd0) && (run_q < 3'd4) && req[last_q];
    assign search_start = lock_active ? last_q : ptr_q;

    always_comb begin
        last_d = last_q;
        run_d  = run_q;
        if (can_grant) begin
            last_d = win_idx;
            run_d  = (lock_active && (win_idx == last_q)) ? run_q + 3'd1 : 3'd1;
        end else if (!req[last_q]) begin
            run_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= '0;
            run_q  <= '0;
        end else begin
            last_q <= last_d;
            run_q  <= run_d;
        end
    end
`else
    assign search_start = ptr_q;
`endif

    // First requester at or after search_start, wrapping modulo NREQ.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(search_start) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        gnt_d   = '0;
        wr_en_d = 1'b0;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        if (can_grant && win_found) begin
            gnt_d   = NREQ'(1) << win_idx;
            wr_en_d = 1'b1;
            wdata_d = wdata_in[int'(win_idx)*WIDTH +: WIDTH];
            ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        if (wr_en_q && !fifo_rd_en) begin
            if (count_q < DEPTH_CNT) begin
                count_d = count_q + CW'(1);
            end
        end else if (!wr_en_q && fifo_rd_en && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d = StIdle;
        if (can_grant) begin
            state_d = StGrant;
        end else if (|req) begin
            state_d = StBlocked;
        end
        stall_d = stall_q;
        if ((state_d == StBlocked) && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
            count_q <= '0;
            stall_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            stall_q <= stall_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt        = gnt_q;
    assign fifo_wr_en = wr_en_q;
    assign fifo_wdata = wdata_q;
    assign count      = count_q;
    assign stall_cnt  = stall_q;
    assign state      = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, checked against a
// cycle-level reference model. Honours WR_ARB_LOCK_EN when defined for the build.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  wdata_in;
    logic                   fifo_full;
    logic                   fifo_rd_en;
    logic [NREQ-1:0]        gnt;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_wdata;
    logic [$clog2(DEPTH):0] count;
    logic [7:0]             stall_cnt;
    logic [1:0]             state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_count, m_ptr, m_wr, m_gnt, m_data, m_state, m_stall, m_last, m_run;

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .wdata_in   (wdata_in),
        .fifo_full  (fifo_full),
        .fifo_rd_en (fifo_rd_en),
        .gnt        (gnt),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .count      (count),
        .stall_cnt  (stall_cnt),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gnt_index(input logic [NREQ-1:0] g);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_count = 0; m_ptr = 0; m_wr = 0; m_gnt = -1; m_data = 0;
        m_state = 0; m_stall = 0; m_last = 0; m_run = 0;
    endtask

    // One rising edge of the arbiter, from the inputs present just before it.
    task automatic model_step();
        bit dec;
        int start, win, idx, nc;
        dec = (req != 0) && !fifo_full && (m_count + m_wr < DEPTH);
        win = -1;
        start = m_ptr;
`ifdef WR_ARB_LOCK_EN
        if (m_run > 0 && m_run < 4 && req[m_last]) start = m_last;
`endif
        if (dec) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (start + k) % NREQ;
                if (win < 0 && req[idx]) win = idx;
            end
        end
        nc = m_count;
        if (m_wr == 1 && !fifo_rd_en) nc = (m_count < DEPTH) ? m_count + 1 : DEPTH;
        else if (m_wr == 0 && fifo_rd_en && m_count > 0) nc = m_count - 1;
        m_count = nc;
        m_state = dec ? 1 : ((req != 0) ? 2 : 0);
        if (m_state == 2 && m_stall < 255) m_stall++;
`ifdef WR_ARB_LOCK_EN
        if (dec) begin
            m_run = (win == m_last && m_run > 0 && m_run < 4) ? m_run + 1 : 1;
            m_last = win;
        end else if (!req[m_last]) begin
            m_run = 0;
        end
`endif
        m_wr  = dec ? 1 : 0;
        m_gnt = win;
        if (dec) begin
            m_data = int'(wdata_in[win*WIDTH +: WIDTH]);
            m_ptr  = (win + 1) % NREQ;
        end
    endtask

    task automatic check_all();
        check_eq("gnt", int'(gnt), (m_gnt >= 0) ? (1 << m_gnt) : 0);
        check_eq("wr_en", int'(fifo_wr_en), m_wr);
        if (m_wr == 1) check_eq("wdata", int'(fifo_wdata), m_data);
        check_eq("count", int'(count), m_count);
        check_eq("stall_cnt", int'(stall_cnt), m_stall);
        check_eq("state", int'(state), m_state);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int obs[$];
        int exp_seq[8];
        int w;
        req = '0; wdata_in = '0; fifo_full = 1'b0; fifo_rd_en = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // All four requesters held, no pops: fills to DEPTH then blocks
        wdata_in = 16'hDCBA;
        req = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            cycle();
            w = gnt_index(gnt);
            if (w >= 0) obs.push_back(w);
        end
`ifdef WR_ARB_LOCK_EN
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        check_eq("fill_grants", obs.size(), 8);
        for (int k = 0; k < 8 && k < obs.size(); k++) check_eq("fill_order", obs[k], exp_seq[k]);
        check_eq("fill_count", int'(count), 8);
        check_eq("fill_state", int'(state), 2);
        check_eq("fill_stall", int'(stall_cnt), 4);

        // Full FIFO, one pop, requester 2 only
        req = 4'b0100;
        fifo_rd_en = 1'b1;
        cycle();
        fifo_rd_en = 1'b0;
        cycle();
        check_eq("pop_gnt2", int'(gnt), 4);
        req = '0;
        cycle();
        check_eq("pop_refill", int'(count), 8);
        cycle();

        // Simultaneous push and pop at count 5, then underflow
        fifo_rd_en = 1'b1;
        repeat (3) cycle();
        fifo_rd_en = 1'b0;
        req = 4'b0001;
        cycle();
        req = '0;
        fifo_rd_en = 1'b1;
        cycle();
        check_eq("push_pop_count", int'(count), 5);
        repeat (8) cycle();
        check_eq("underflow_count", int'(count), 0);
        fifo_rd_en = 1'b0;

        // fifo_full forced at count 3
        req = 4'b0001;
        repeat (3) cycle();
        fifo_full = 1'b1;
        cycle();
        check_eq("full_count", int'(count), 3);
        repeat (4) cycle();
        check_eq("full_gnt", int'(gnt), 0);
        check_eq("full_state", int'(state), 2);
        fifo_full = 1'b0;
        cycle();
        check_eq("full_release_wr", int'(fifo_wr_en), 1);
        req = '0;
        cycle();

        // Reset in the cycle after a grant decision
        req = 4'b0010;
        cycle();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cycle();
            check_eq("post_reset_wr", int'(fifo_wr_en), 0);
        end

        // Two held requesters: lock vs strict round-robin
        do_reset();
        req = 4'b0011;
        fifo_rd_en = 1'b1;
        obs.delete();
        for (int c = 0; c < 9; c++) begin
            cycle();
            w = gnt_index(gnt);
            if (w >= 0) obs.push_back(w);
        end
`ifdef WR_ARB_LOCK_EN
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        for (int k = 0; k < 8 && k < obs.size(); k++) check_eq("pair_order", obs[k], exp_seq[k]);
        check_eq("pair_grants", obs.size(), 9);
        req = '0;
        fifo_rd_en = 1'b0;
        cycle();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(149, 0) == 0) begin
                do_reset();
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && gnt[i] && $urandom_range(1, 0) == 1) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                    wdata_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            fifo_rd_en = ($urandom_range(2, 0) == 0);
            fifo_full  = ($urandom_range(7, 0) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have the parameter NREQ, default 4, giving the number of write requesters (2..4).
REQ-002 The block SHALL have the parameter WIDTH, default 4, giving the data word width.
REQ-003 The block SHALL have the parameter DEPTH, default 8, giving the downstream FIFO depth (power of 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester write request, held high until granted.
REQ-007 The block SHALL have port wdata_in, input, NREQ*WIDTH bits: requester i's data in bits [i*WIDTH +: WIDTH], stable while req[i] is high.
REQ-008 The block SHALL have port fifo_full, input, 1 bit: full flag from the FIFO.
REQ-009 The block SHALL have port fifo_rd_en, input, 1 bit: FIFO pop strobe, used for occupancy tracking.
REQ-010 The block SHALL have port gnt, output, NREQ bits: one-hot, registered, one-cycle acknowledge to the winning requester.
REQ-011 The block SHALL have port fifo_wr_en, output, 1 bit: registered push strobe to the FIFO.
REQ-012 The block SHALL have port fifo_wdata, output, WIDTH bits: registered push data.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: tracked FIFO occupancy.
REQ-014 The block SHALL have port stall_cnt, output, 8 bits: saturating count of blocked cycles.
REQ-015 The block SHALL have port state, output, 2 bits: FSM state (IDLE=0, GRANT=1, BLOCKED=2).

Function
REQ-016 At each rising edge, a grant SHALL be decided when any req bit is high, fifo_full is 0, and count + fifo_wr_en < DEPTH.
REQ-017 The winner SHALL be the first requester with req high, searching round-robin from ptr, the index after the last granted requester.
REQ-018 In the cycle after the decision, gnt SHALL be one-hot on the winner, fifo_wr_en SHALL be 1, and fifo_wdata SHALL equal the winner's wdata_in slice sampled at the decision edge; latency is 1 cycle.
REQ-019 gnt and fifo_wr_en SHALL be 0 in every cycle with no grant decision, and gnt SHALL never have more than one bit set.
REQ-020 Each rising edge SHALL update count as: +1 when fifo_wr_en=1 alone, -1 when fifo_rd_en=1 alone, unchanged when both are 1 or neither is.
REQ-021 When fifo_rd_en=1 with count=0 (underflow), count SHALL stay 0; count SHALL never exceed DEPTH.
REQ-022 A requester that was granted and still holds req in the next cycle SHALL be treated as making a new request.
REQ-023 The FSM SHALL be IDLE when no req is high, GRANT when a grant is decided, and BLOCKED when any req is high and no grant is decided; it SHALL be re-evaluated every edge.
REQ-024 stall_cnt SHALL increment by 1 on each edge where the FSM enters or stays in BLOCKED, and SHALL saturate at 255.
REQ-025 When fifo_full=1 while count < DEPTH, fifo_full SHALL take precedence and no grant SHALL be issued.

Reset
REQ-026 When reset is high, gnt, fifo_wr_en, fifo_wdata, count, stall_cnt and ptr SHALL be cleared to 0 and state SHALL be IDLE, immediately and independent of clk.
REQ-027 A reset asserted mid-operation SHALL abort any pending grant, and no fifo_wr_en SHALL follow reset release.
REQ-028 The first grant decision after reset release SHALL occur at the first rising edge on which reset is low.

Configuration
REQ-029 When WR_ARB_LOCK_EN is defined, the last winner SHALL keep priority while its req stays high, for up to 4 consecutive grants; ptr SHALL then advance, and the lock SHALL release early if that req drops.
REQ-030 When WR_ARB_LOCK_EN is undefined, ptr SHALL advance after every grant (strict round-robin), and no lock logic SHALL be present.

Verification
REQ-031 Verification SHALL cover: reset, then req=4'b1111 with fifo_rd_en=0 -> grants to requesters 0,1,2,3,0,1,2,3 on consecutive cycles; count reaches 8; state=BLOCKED; stall_cnt increments.
REQ-032 Verification SHALL cover: count=8 with one fifo_rd_en pulse and req=4'b0100 -> exactly one grant to requester 2 the following cycle, and count returns to 8.
REQ-033 Verification SHALL cover: simultaneous fifo_wr_en=1 and fifo_rd_en=1 at count=5 -> count stays 5; fifo_rd_en at count=0 -> count stays 0.
REQ-034 Verification SHALL cover: fifo_full=1 forced at count=3 with req=4'b0001 -> no gnt, state=BLOCKED, stall_cnt rising until fifo_full drops.
REQ-035 Verification SHALL cover: reset asserted the cycle after a grant decision -> gnt=0, fifo_wr_en=0, count=0 immediately, with no push after release.
REQ-036 Verification SHALL cover: with WR_ARB_LOCK_EN defined and req=4'b0011 held -> grants 0,0,0,0,1,1,1,1; with it undefined -> grants 0,1,0,1.
